// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage definitions: fetch FSM encoding and instruction/PC constants.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam int unsigned PC_STEP   = 4;

endpackage

// File: rtl/fetch_buffer.sv
// One-entry holding buffer for an instruction that returned while decode was stalled.
module fetch_buffer
    import fetch_unit_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               clear,
    input  logic [INSTR_W-1:0] load_instr,
    input  logic [ADDR_W-1:0]  load_pc,
    output logic               valid,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  pc
);

    logic               valid_q, valid_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;

    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        if (clear) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            instr_d = load_instr;
            pc_d    = load_pc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            instr_q <= INSTR_W'(NOP_INSTR);
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    assign valid = valid_q;
    assign instr = instr_q;
    assign pc    = pc_q;

    // A held instruction must be consumed or flushed before another can arrive.
    buf_no_overwrite: assert property (@(posedge clk) disable iff (rst) load |-> !valid_q);

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage with IF/ID register: PC sequencing, single-outstanding
// memory request tracking, branch redirect/drain and stall buffering.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enPC,
    input  logic               enIfId,
    input  logic               rstIfId,
    input  logic               branchTaken,
    input  logic [ADDR_W-1:0]  branchTarget,
    output logic               imemReq,
    output logic [ADDR_W-1:0]  imemAddr,
    input  logic               imemRvalid,
    input  logic [INSTR_W-1:0] imemRdata,
    output logic [INSTR_W-1:0] ifIdInstr,
    output logic [ADDR_W-1:0]  ifIdPC,
    output logic               ifIdValid,
    output logic [31:0]        bubbleCount,
    output fetch_state_e       dbg_state
);

    fetch_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  req_pc_q, req_pc_d;
    logic [INSTR_W-1:0] if_id_instr_q, if_id_instr_d;
    logic [ADDR_W-1:0]  if_id_pc_q, if_id_pc_d;
    logic               if_id_valid_q, if_id_valid_d;
    logic [31:0]        bubble_count_q, bubble_count_d;

    logic               rsp_wait, flush, avail, issue;
    logic               buf_load, buf_clear, buf_valid;
    logic [INSTR_W-1:0] buf_instr, src_instr;
    logic [ADDR_W-1:0]  buf_pc, src_pc;

    fetch_buffer #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) u_buf (
        .clk        (clk),
        .rst        (rst),
        .load       (buf_load),
        .clear      (buf_clear),
        .load_instr (imemRdata),
        .load_pc    (req_pc_q),
        .valid      (buf_valid),
        .instr      (buf_instr),
        .pc         (buf_pc)
    );

    always_comb begin
        rsp_wait  = (state_q == ST_WAIT) && imemRvalid;
        flush     = branchTaken || rstIfId;
        avail     = buf_valid || rsp_wait;
        src_instr = buf_valid ? buf_instr : imemRdata;
        src_pc    = buf_valid ? buf_pc : req_pc_q;
        // Chained issue only when the returning instruction is consumed by decode this cycle.
        issue     = enPC && !branchTaken && !buf_valid &&
                    ((state_q == ST_IDLE) || (rsp_wait && enIfId && !rstIfId));
        buf_clear = branchTaken || (enIfId && !flush);
        buf_load  = rsp_wait && !branchTaken && !(enIfId && !rstIfId);

        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        if (branchTaken) begin
            // A response still in flight for the old path must be swallowed.
            state_d = ((state_q == ST_IDLE) || imemRvalid) ? ST_IDLE : ST_DRAIN;
            pc_d    = branchTarget;
        end else if (issue) begin
            state_d  = ST_WAIT;
            pc_d     = pc_q + ADDR_W'(PC_STEP);
            req_pc_d = pc_q;
        end else if ((state_q != ST_IDLE) && imemRvalid) begin
            state_d = ST_IDLE;
        end

        if_id_instr_d  = if_id_instr_q;
        if_id_pc_d     = if_id_pc_q;
        if_id_valid_d  = if_id_valid_q;
        bubble_count_d = bubble_count_q;
        if (enIfId) begin
            if (flush) begin
                if_id_valid_d = 1'b0;
                if_id_instr_d = INSTR_W'(NOP_INSTR);
            end else if (avail) begin
                if_id_valid_d = 1'b1;
                if_id_instr_d = src_instr;
                if_id_pc_d    = src_pc;
            end else begin
                if_id_valid_d  = 1'b0;
                if_id_instr_d  = INSTR_W'(NOP_INSTR);
                bubble_count_d = bubble_count_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            pc_q           <= RESET_PC;
            req_pc_q       <= '0;
            if_id_instr_q  <= INSTR_W'(NOP_INSTR);
            if_id_pc_q     <= '0;
            if_id_valid_q  <= 1'b0;
            bubble_count_q <= 32'd0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            req_pc_q       <= req_pc_d;
            if_id_instr_q  <= if_id_instr_d;
            if_id_pc_q     <= if_id_pc_d;
            if_id_valid_q  <= if_id_valid_d;
            bubble_count_q <= bubble_count_d;
        end
    end

    assign imemReq     = issue && !rst;
    assign imemAddr    = pc_q;
    assign ifIdInstr   = if_id_instr_q;
    assign ifIdPC      = if_id_pc_q;
    assign ifIdValid   = if_id_valid_q;
    assign bubbleCount = bubble_count_q;
    assign dbg_state   = state_q;

    // A new request leaves only from IDLE or as the outstanding one completes.
    one_outstanding: assert property (@(posedge clk) disable iff (rst)
        imemReq |-> ((state_q == ST_IDLE) || ((state_q == ST_WAIT) && imemRvalid)));

endmodule
